mem_port_arbiter: RTL and testbench

- Sequences the single unified instruction/data memory of the pipelined 8-bit core among three requesters:
  - vector reads (reset vector M[0], interrupt vector M[1]);
  - MEM-stage data accesses (LDD/STD/PUSH/POP/CALL/RET/interrupt push);
  - IF-stage instruction fetch.
- Generates the fetch stall that the control unit combines into PC_Write_En / IF_ID_Write_En.
- Sits between the pipeline stages and the memory macro.

---
 rtl/mem_port_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Sequences the shared instruction/data memory among vector, data and fetch requesters (vec > d > if).
// Optional fetch starvation guard: define ARB_FETCH_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vec_req,
    input  logic              vec_sel,
    output logic [DATA_W-1:0] vec_rdata,
    output logic              vec_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = 3;

    if (MEM_LAT < 1 || MEM_LAT > 4 || STARVE_MAX < 1) begin : g_bad_param
        $error("mem_port_arbiter: MEM_LAT must be 1..4 and STARVE_MAX at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VEC,
        OWN_D,
        OWN_IF
    } owner_t;

    state_t             state_q, state_d;
    owner_t             owner_q, owner_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic               mem_en_d, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d;
    logic [DATA_W-1:0]  vec_rdata_d, d_rdata_d, if_rdata_d;
    logic               vec_valid_d, d_valid_d, if_valid_d;
    logic               grant_vec_c, grant_d_c, grant_if_c;
    logic               fetch_boost_c;

    // Winner selection; the boost lets a starved fetch jump ahead of data only.
    always_comb begin
        grant_vec_c = vec_req;
        grant_d_c   = !vec_req && d_req && !fetch_boost_c;
        grant_if_c  = !vec_req && if_req && (!d_req || fetch_boost_c);
    end

`ifdef ARB_FETCH_STARVE_GUARD_EN
    localparam int unsigned SC_W = $clog2(STARVE_MAX + 1);

    logic [SC_W-1:0] starve_q, starve_d;
    logic            any_grant_c;

    assign fetch_boost_c = if_req && (starve_q == SC_W'(STARVE_MAX));
    assign any_grant_c   = (state_q == S_IDLE) && (vec_req || d_req || if_req);

    // Counts data grants taken while fetch is waiting; vector grants leave it alone.
    always_comb begin
        starve_d = starve_q;
        if (any_grant_c) begin
            if (grant_if_c || !if_req) begin
                starve_d = '0;
            end else if (grant_d_c && (starve_q != SC_W'(STARVE_MAX))) begin
                starve_d = starve_q + SC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign fetch_boost_c = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        vec_rdata_d = vec_rdata;
        d_rdata_d   = d_rdata;
        if_rdata_d  = if_rdata;
        vec_valid_d = 1'b0;
        d_valid_d   = 1'b0;
        if_valid_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_vec_c || grant_d_c || grant_if_c) begin
                    state_d  = S_WAIT;
                    mem_en_d = 1'b1;
                    cnt_d    = CNT_W'(MEM_LAT);
                    if (grant_vec_c) begin
                        owner_d     = OWN_VEC;
                        we_d        = 1'b0;
                        mem_addr_d  = ADDR_W'(vec_sel);
                        mem_wdata_d = '0;
                    end else if (grant_d_c) begin
                        owner_d     = OWN_D;
                        we_d        = d_we;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        owner_d     = OWN_IF;
                        we_d        = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                    end
                end
            end

            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_RESP;
                    unique case (owner_q)
                        OWN_VEC: begin
                            vec_rdata_d = mem_rdata;
                            vec_valid_d = 1'b1;
                        end
                        OWN_D: begin
                            if (!we_q) begin
                                d_rdata_d = mem_rdata;
                            end
                            d_valid_d = 1'b1;
                        end
                        OWN_IF: begin
                            if_rdata_d = mem_rdata;
                            if_valid_d = 1'b1;
                        end
                        default: begin
                            state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end

            default: begin
                state_d = S_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_NONE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            vec_rdata <= '0;
            d_rdata   <= '0;
            if_rdata  <= '0;
            vec_valid <= 1'b0;
            d_valid   <= 1'b0;
            if_valid  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            mem_en    <= mem_en_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            vec_rdata <= vec_rdata_d;
            d_rdata   <= d_rdata_d;
            if_rdata  <= if_rdata_d;
            vec_valid <= vec_valid_d;
            d_valid   <= d_valid_d;
            if_valid  <= if_valid_d;
        end
    end

    assign if_stall = if_req & ~if_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) with their own memory models.
module tb_mem_port_arbiter;

    localparam int unsigned STARVE_MAX = 3;

    logic       clk;
    logic       rst;
    logic       vec_req   [2];
    logic       vec_sel   [2];
    logic [7:0] vec_rdata [2];
    logic       vec_valid [2];
    logic       d_req     [2];
    logic       d_we      [2];
    logic [7:0] d_addr    [2];
    logic [7:0] d_wdata   [2];
    logic [7:0] d_rdata   [2];
    logic       d_valid   [2];
    logic       if_req    [2];
    logic [7:0] if_addr   [2];
    logic [7:0] if_rdata  [2];
    logic       if_valid  [2];
    logic       if_stall  [2];
    logic       mem_en    [2];
    logic       mem_we    [2];
    logic [7:0] mem_addr  [2];
    logic [7:0] mem_wdata [2];
    logic [7:0] mem_rdata [2];

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(1), .STARVE_MAX(STARVE_MAX)) u_dut (
        .clk(clk), .rst(rst),
        .vec_req(vec_req[0]), .vec_sel(vec_sel[0]), .vec_rdata(vec_rdata[0]), .vec_valid(vec_valid[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_valid(d_valid[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rdata(if_rdata[0]), .if_valid(if_valid[0]),
        .if_stall(if_stall[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
        .mem_rdata(mem_rdata[0])
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(3), .STARVE_MAX(STARVE_MAX)) u_dut_lat3 (
        .clk(clk), .rst(rst),
        .vec_req(vec_req[1]), .vec_sel(vec_sel[1]), .vec_rdata(vec_rdata[1]), .vec_valid(vec_valid[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_valid(d_valid[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rdata(if_rdata[1]), .if_valid(if_valid[1]),
        .if_stall(if_stall[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
        .mem_rdata(mem_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int a);
        case (a)
            0:       return 8'h2A;
            1:       return 8'h3C;
            16:      return 8'h5C;
            128:     return 8'h11;
            default: return 8'((a * 37 + 11) & 255);
        endcase
    endfunction

    // Memory macro models: registered read with a per-instance latency, junk when no read is due.
    logic [7:0] mem    [2][256];
    logic [7:0] pipe_d [2][4];
    logic       pipe_v [2][4];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                for (int a = 0; a < 256; a++) mem[i][a] <= init_byte(a);
                for (int k = 0; k < 4; k++) pipe_v[i][k] <= 1'b0;
            end else begin
                if (mem_en[i] && mem_we[i]) mem[i][mem_addr[i]] <= mem_wdata[i];
                pipe_v[i][0] <= mem_en[i] && !mem_we[i];
                pipe_d[i][0] <= mem[i][mem_addr[i]];
                for (int k = 1; k < 4; k++) begin
                    pipe_v[i][k] <= pipe_v[i][k-1];
                    pipe_d[i][k] <= pipe_d[i][k-1];
                end
            end
        end
    end

    assign mem_rdata[0] = pipe_v[0][0] ? pipe_d[0][0] : 8'hEE;
    assign mem_rdata[1] = pipe_v[1][2] ? pipe_d[1][2] : 8'hEE;

    // Reference state: expected memory contents and last completed rdata per requester.
    logic [7:0] ref_mem [2][256];
    logic [7:0] exp_rd  [2][3];
    int n_checks;
    int n_fail;

    task automatic reset_model();
        for (int i = 0; i < 2; i++) begin
            for (int a = 0; a < 256; a++) ref_mem[i][a] = init_byte(a);
            for (int r = 0; r < 3; r++) exp_rd[i][r] = 8'h00;
        end
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            vec_req[i] = 1'b0; vec_sel[i] = 1'b0;
            d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = 8'h00; d_wdata[i] = 8'h00;
            if_req[i] = 1'b0; if_addr[i] = 8'h00;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({mem_en[i], mem_we[i], vec_valid[i], d_valid[i], if_valid[i], if_stall[i],
                 mem_addr[i], mem_wdata[i], vec_rdata[i], d_rdata[i], if_rdata[i]} !== 46'h0) begin
                n_fail++;
                $display("FAIL reset_state inst%0d: got en=%b we=%b vv=%b dv=%b iv=%b st=%b addr=%h wd=%h rd=%h/%h/%h, expected all zero",
                         i, mem_en[i], mem_we[i], vec_valid[i], d_valid[i], if_valid[i], if_stall[i],
                         mem_addr[i], mem_wdata[i], vec_rdata[i], d_rdata[i], if_rdata[i]);
            end
        end
        rst = 1'b1;
        reset_model();
    endtask

    // Requests start at the given cycle (-1 = absent); the schedule is derived from the grant rules.
    task automatic run_scenario(input int inst, input int sv, input logic vsel,
                                input int sd, input logic dwe, input logic [7:0] daddr,
                                input logic [7:0] dwdata, input int si, input logic [7:0] iaddr,
                                input string tag);
        int lat, free_at, last, owner;
        int start [3];
        int en_cyc [3];
        int val_cyc [3];
        logic [7:0] addr_of [3];
        logic [7:0] data_of [3];
        logic we_of [3];
        bit done [3];
        bit granted;
        logic [4:0] exp_ctrl, got_ctrl;

        lat = (inst == 0) ? 1 : 3;
        start[0] = sv; start[1] = sd; start[2] = si;
        addr_of[0] = {7'b0, vsel}; addr_of[1] = daddr; addr_of[2] = iaddr;
        we_of[0] = 1'b0; we_of[1] = dwe; we_of[2] = 1'b0;
        last = 0;
        for (int r = 0; r < 3; r++) begin
            en_cyc[r] = -1; val_cyc[r] = -1; done[r] = 1'b0; data_of[r] = 8'h00;
            if (start[r] > last) last = start[r];
        end
        free_at = 0;
        for (int t = 0; t < 64; t++) begin
            granted = 1'b0;
            if (t >= free_at) begin
                for (int r = 0; r < 3; r++) begin
                    if (!granted && !done[r] && start[r] >= 0 && start[r] <= t) begin
                        granted = 1'b1;
                        done[r] = 1'b1;
                        en_cyc[r] = t + 1;
                        val_cyc[r] = t + lat + 2;
                        free_at = t + lat + 3;
                        if (free_at > last) last = free_at;
                        if (we_of[r]) ref_mem[inst][addr_of[r]] = dwdata;
                        else data_of[r] = ref_mem[inst][addr_of[r]];
                    end
                end
            end
        end

        for (int c = 0; c <= last; c++) begin
            @(posedge clk);
            #1;
            if (start[0] == c) begin vec_req[inst] = 1'b1; vec_sel[inst] = vsel; end
            if (start[1] == c) begin
                d_req[inst] = 1'b1; d_we[inst] = dwe; d_addr[inst] = daddr; d_wdata[inst] = dwdata;
            end
            if (start[2] == c) begin if_req[inst] = 1'b1; if_addr[inst] = iaddr; end
            if (val_cyc[0] >= 0 && c == val_cyc[0] + 1) vec_req[inst] = 1'b0;
            if (val_cyc[1] >= 0 && c == val_cyc[1] + 1) d_req[inst] = 1'b0;
            if (val_cyc[2] >= 0 && c == val_cyc[2] + 1) if_req[inst] = 1'b0;
            @(negedge clk);
            owner = -1;
            exp_ctrl = 5'b0;
            for (int r = 0; r < 3; r++) begin
                if (en_cyc[r] == c) begin owner = r; exp_ctrl[4] = 1'b1; end
                if (val_cyc[r] == c) begin
                    exp_ctrl[3-r] = 1'b1;
                    if (!we_of[r]) exp_rd[inst][r] = data_of[r];
                end
            end
            exp_ctrl[0] = (start[2] >= 0) && (c >= start[2]) && (c < val_cyc[2]);
            got_ctrl = {mem_en[inst], vec_valid[inst], d_valid[inst], if_valid[inst], if_stall[inst]};
            n_checks++;
            if (got_ctrl !== exp_ctrl) begin
                n_fail++;
                $display("FAIL %s ctrl inst%0d cycle %0d: {en,vv,dv,iv,stall} got %b expected %b",
                         tag, inst, c, got_ctrl, exp_ctrl);
            end
            n_checks++;
            if ({vec_rdata[inst], d_rdata[inst], if_rdata[inst]} !==
                {exp_rd[inst][0], exp_rd[inst][1], exp_rd[inst][2]}) begin
                n_fail++;
                $display("FAIL %s rdata inst%0d cycle %0d: vec/d/if got %h/%h/%h expected %h/%h/%h",
                         tag, inst, c, vec_rdata[inst], d_rdata[inst], if_rdata[inst],
                         exp_rd[inst][0], exp_rd[inst][1], exp_rd[inst][2]);
            end
            if (owner >= 0) begin
                n_checks++;
                if ({mem_we[inst], mem_addr[inst]} !== {we_of[owner], addr_of[owner]} ||
                    (we_of[owner] && mem_wdata[inst] !== dwdata)) begin
                    n_fail++;
                    $display("FAIL %s access inst%0d cycle %0d: we=%b addr=%h wdata=%h expected we=%b addr=%h wdata=%h",
                             tag, inst, c, mem_we[inst], mem_addr[inst], mem_wdata[inst],
                             we_of[owner], addr_of[owner], dwdata);
                end
            end
        end
    endtask

    task automatic test_vector_read();
        run_scenario(0, 0, 1'b0, -1, 1'b0, 8'h00, 8'h00, -1, 8'h00, "vec_reset");
        run_scenario(0, 0, 1'b1, -1, 1'b0, 8'h00, 8'h00, -1, 8'h00, "vec_irq");
    endtask

    task automatic test_data_vs_fetch();
        run_scenario(0, -1, 1'b0, 0, 1'b0, 8'h80, 8'h00, 0, 8'h10, "d_vs_if");
    endtask

    task automatic test_write_readback();
        run_scenario(0, -1, 1'b0, 0, 1'b1, 8'hFE, 8'h77, -1, 8'h00, "d_write");
        run_scenario(0, -1, 1'b0, 0, 1'b0, 8'hFE, 8'h00, -1, 8'h00, "d_readback");
    endtask

    task automatic test_lat3();
        run_scenario(1, 2, 1'b0, -1, 1'b0, 8'h00, 8'h00, 0, 8'h10, "lat3_fetch_vec");
    endtask

    // Owner drops req and changes payload mid-access: the latched read still completes.
    task automatic test_no_cancel();
        logic [7:0] expd;
        expd = ref_mem[0][8'h80];
        @(posedge clk); #1;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h80;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (mem_en[0] !== 1'b1 || mem_addr[0] !== 8'h80) begin
            n_fail++;
            $display("FAIL no_cancel_grant: en=%b addr=%h expected en=1 addr=80", mem_en[0], mem_addr[0]);
        end
        @(posedge clk); #1;
        d_req[0] = 1'b0; d_addr[0] = 8'h10; d_we[0] = 1'b1; d_wdata[0] = 8'h99;
        @(posedge clk); #1;
        @(negedge clk);
        exp_rd[0][1] = expd;
        n_checks++;
        if (d_valid[0] !== 1'b1 || d_rdata[0] !== expd) begin
            n_fail++;
            $display("FAIL no_cancel_done: d_valid=%b d_rdata=%h expected 1/%h", d_valid[0], d_rdata[0], expd);
        end
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (mem_en[0] !== 1'b0 || d_valid[0] !== 1'b0 || d_rdata[0] !== expd) begin
                n_fail++;
                $display("FAIL no_cancel_idle: en=%b d_valid=%b d_rdata=%h expected 0/0/%h",
                         mem_en[0], d_valid[0], d_rdata[0], expd);
            end
        end
        d_we[0] = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        @(posedge clk); #1;
        d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h80;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (mem_en[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_rst_pre: mem_en got %b expected 1", mem_en[0]);
        end
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({mem_en[0], mem_we[0], vec_valid[0], d_valid[0], if_valid[0],
             mem_addr[0], mem_wdata[0], vec_rdata[0], d_rdata[0], if_rdata[0]} !== 45'h0) begin
            n_fail++;
            $display("FAIL mid_rst_clear: en=%b addr=%h dv=%b d_rdata=%h expected all zero",
                     mem_en[0], mem_addr[0], d_valid[0], d_rdata[0]);
        end
        d_req[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if ({mem_en[0], vec_valid[0], d_valid[0], if_valid[0]} !== 4'b0) begin
                n_fail++;
                $display("FAIL mid_rst_hold: {en,vv,dv,iv} got %b expected 0000",
                         {mem_en[0], vec_valid[0], d_valid[0], if_valid[0]});
            end
        end
        rst = 1'b1;
        reset_model();
        run_scenario(0, -1, 1'b0, 0, 1'b0, 8'h80, 8'h00, -1, 8'h00, "after_rst");
    endtask

    // Data and fetch held continuously; grant order from the starvation rule.
    task automatic test_starve_guard();
        int order [$];
        int cnt, nd, g, d_drop, if_drop, k;
        bit ifp, guard;
        logic [7:0] exp_addr;
`ifdef ARB_FETCH_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        cnt = 0; nd = 0; ifp = 1'b1;
        while (nd < 6 || ifp) begin
            if (ifp && guard && cnt == int'(STARVE_MAX)) begin
                order.push_back(2); cnt = 0; ifp = 1'b0;
            end else if (nd < 6) begin
                order.push_back(1); nd++; cnt = ifp ? cnt + 1 : 0;
            end else begin
                order.push_back(2); ifp = 1'b0; cnt = 0;
            end
        end
        g = order.size();
        d_drop = -1; if_drop = -1; nd = 0;
        for (int i = 0; i < g; i++) begin
            if (order[i] == 1) begin nd++; if (nd == 6) d_drop = 4 * i + 4; end
            else if_drop = 4 * i + 4;
        end
        for (int c = 0; c <= 4 * g; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h80;
                if_req[0] = 1'b1; if_addr[0] = 8'h10;
            end
            if (c == d_drop) d_req[0] = 1'b0;
            if (c == if_drop) if_req[0] = 1'b0;
            @(negedge clk);
            k = c / 4;
            if (k < g && (c % 4) == 1) begin
                exp_addr = (order[k] == 1) ? 8'h80 : 8'h10;
                n_checks++;
                if (mem_en[0] !== 1'b1 || mem_addr[0] !== exp_addr) begin
                    n_fail++;
                    $display("FAIL starve_grant %0d: en=%b addr=%h expected en=1 addr=%h",
                             k, mem_en[0], mem_addr[0], exp_addr);
                end
            end
            if (k < g && (c % 4) == 3) begin
                if (order[k] == 1) exp_rd[0][1] = ref_mem[0][8'h80];
                else exp_rd[0][2] = ref_mem[0][8'h10];
                n_checks++;
                if ({d_valid[0], if_valid[0]} !== ((order[k] == 1) ? 2'b10 : 2'b01)) begin
                    n_fail++;
                    $display("FAIL starve_valid %0d: {dv,iv} got %b expected order %0d",
                             k, {d_valid[0], if_valid[0]}, order[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        int inst, sv, sd, si;
        for (int n = 0; n < 24; n++) begin
            inst = int'($urandom_range(0, 1));
            sv = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 6)) : -1;
            sd = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6)) : -1;
            si = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_scenario(inst, sv, 1'($urandom_range(0, 1)), sd, 1'($urandom_range(0, 1)),
                         8'($urandom), 8'($urandom), si, 8'($urandom), "random");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_vector_read();
        test_data_vs_fetch();
        test_write_readback();
        test_lat3();
        test_no_cancel();
        test_reset_mid_access();
        test_starve_guard();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
